// File: rtl/ctrl_spi_slave_pkg.sv
// Shared definitions for the control-channel SPI responder and its register lists.
// Contents: width defaults, opcode constants, FSM state encoding and a width helper.
package ctrl_spi_slave_pkg;

  // Width defaults shared with the fix/pix/frame register lists
  localparam int unsigned DEF_SPI_ADDR_LENGTH = 16;
  localparam int unsigned DEF_SHORT_REG_WD    = 16;
  localparam int unsigned DEF_CMD_WD          = 8;

  // Frame opcodes
  localparam logic [7:0] CMD_WR = 8'h80;
  localparam logic [7:0] CMD_RD = 8'h81;

  // Frame decoder states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_WR_DATA = 3'd4,
    ST_WAIT_CS = 3'd5
  } spi_state_e;

  // Largest of three field widths; sizes the shared rx shift register
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ctrl_spi_slave_if.sv
// Register-list bus between the SPI responder and the fix/pix/frame lists.
// master: responder side (drives rd_en/addr/wr strobe, receives sel + read data per list)
// slave : register-list side
interface ctrl_spi_slave_if
  import ctrl_spi_slave_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_SPI_ADDR_LENGTH,
  parameter int unsigned DATA_W = DEF_SHORT_REG_WD
) ();

  logic              o_rd_en;
  logic [ADDR_W-1:0] ov_addr;
  logic              o_wr_en;
  logic [DATA_W-1:0] ov_wr_data;
  logic              i_fix_sel;
  logic [DATA_W-1:0] iv_fix_rd_data;
  logic              i_pix_sel;
  logic [DATA_W-1:0] iv_pix_rd_data;
  logic              i_frame_sel;
  logic [DATA_W-1:0] iv_frame_rd_data;

  modport master (
    output o_rd_en, ov_addr, o_wr_en, ov_wr_data,
    input  i_fix_sel, iv_fix_rd_data, i_pix_sel, iv_pix_rd_data,
           i_frame_sel, iv_frame_rd_data
  );

  modport slave (
    input  o_rd_en, ov_addr, o_wr_en, ov_wr_data,
    output i_fix_sel, iv_fix_rd_data, i_pix_sel, iv_pix_rd_data,
           i_frame_sel, iv_frame_rd_data
  );

endinterface

// File: rtl/ctrl_spi_slave_spi_sync_edge.sv
// Synchronizes the asynchronous SPI pins into clk_sample and detects edges.
// Ports: clk_sample/reset_n; spi_clk, spi_cs_n, spi_mosi pins in;
//        spi_clk_rise_c/spi_clk_fall_c single-cycle pulses, cs_fall_c pulse,
//        cs_n_sync and mosi_sync synchronized levels.
module spi_sync_edge (
  input  logic clk_sample,
  input  logic reset_n,
  input  logic spi_clk,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic spi_clk_rise_c,
  output logic spi_clk_fall_c,
  output logic cs_fall_c,
  output logic cs_n_sync,
  output logic mosi_sync
);

  logic [2:0] clk_sr;
  logic [2:0] cs_sr;
  logic [1:0] mosi_sr;

  // cs_n flops reset low so a chip select already held low when reset releases
  // never looks like a falling edge; decoding waits for a genuine new frame.
  always_ff @(posedge clk_sample or negedge reset_n) begin
    if (!reset_n) begin
      clk_sr  <= '0;
      cs_sr   <= '0;
      mosi_sr <= '0;
    end else begin
      clk_sr  <= {clk_sr[1:0], spi_clk};
      cs_sr   <= {cs_sr[1:0], spi_cs_n};
      mosi_sr <= {mosi_sr[0], spi_mosi};
    end
  end

  assign spi_clk_rise_c = clk_sr[1] & ~clk_sr[2];
  assign spi_clk_fall_c = ~clk_sr[1] & clk_sr[2];
  assign cs_fall_c      = ~cs_sr[1] & cs_sr[2];
  assign cs_n_sync      = cs_sr[1];
  assign mosi_sync      = mosi_sr[1];

endmodule

// File: rtl/ctrl_spi_slave.sv
// Control-channel SPI responder (CPOL=0/CPHA=0, MSB first).
// Frame: opcode (CMD_WD) + address (SPI_ADDR_LENGTH) + data (SHORT_REG_WD).
// Ports: clk_sample/reset_n; i_spi_clk, i_spi_cs_n, i_spi_mosi host pins; o_spi_miso;
//        reg_bus (master): rd_en/addr/wr_en/wr_data out, fix/pix/frame sel + data in.
module ctrl_spi_slave
  import ctrl_spi_slave_pkg::*;
#(
  parameter int unsigned SPI_ADDR_LENGTH = DEF_SPI_ADDR_LENGTH,
  parameter int unsigned SHORT_REG_WD    = DEF_SHORT_REG_WD,
  parameter int unsigned CMD_WD          = DEF_CMD_WD
) (
  input  logic             clk_sample,
  input  logic             reset_n,
  input  logic             i_spi_clk,
  input  logic             i_spi_cs_n,
  input  logic             i_spi_mosi,
  output logic             o_spi_miso,
  ctrl_spi_slave_if.master reg_bus
);

  localparam int unsigned RX_W  = max3(CMD_WD, SPI_ADDR_LENGTH, SHORT_REG_WD);
  localparam int unsigned CNT_W = $clog2(RX_W + 1);

  logic spi_clk_rise_c, spi_clk_fall_c, cs_fall_c, cs_n_sync, mosi_sync;

  spi_state_e state_q, state_d;
  logic [CNT_W-1:0]           bit_cnt_q;
  logic [RX_W-2:0]            rx_sr_q;
  logic [RX_W-1:0]            rx_word_c;
  logic [CMD_WD-1:0]          cmd_word_c;
  logic [SHORT_REG_WD-1:0]    tx_sr_q;
  logic [SHORT_REG_WD-1:0]    rd_mux_c;
  logic [SPI_ADDR_LENGTH-1:0] addr_q;
  logic [SHORT_REG_WD-1:0]    wr_data_q;
  logic is_rd_q, load_q, rd_en_q, wr_en_q;
  logic last_bit_c, field_done_c, cmd_valid_c;

  spi_sync_edge u_sync (
    .clk_sample     (clk_sample),
    .reset_n        (reset_n),
    .spi_clk        (i_spi_clk),
    .spi_cs_n       (i_spi_cs_n),
    .spi_mosi       (i_spi_mosi),
    .spi_clk_rise_c (spi_clk_rise_c),
    .spi_clk_fall_c (spi_clk_fall_c),
    .cs_fall_c      (cs_fall_c),
    .cs_n_sync      (cs_n_sync),
    .mosi_sync      (mosi_sync)
  );

  // Word including the bit being captured on this rise
  assign rx_word_c   = {rx_sr_q, mosi_sync};
  assign cmd_word_c  = rx_word_c[CMD_WD-1:0];
  assign cmd_valid_c = (cmd_word_c == CMD_WD'(CMD_WR)) || (cmd_word_c == CMD_WD'(CMD_RD));

  // Field length of the current state
  always_comb begin
    last_bit_c = 1'b0;
    case (state_q)
      ST_CMD:                 last_bit_c = (bit_cnt_q == CNT_W'(CMD_WD - 1));
      ST_ADDR:                last_bit_c = (bit_cnt_q == CNT_W'(SPI_ADDR_LENGTH - 1));
      ST_RD_DATA, ST_WR_DATA: last_bit_c = (bit_cnt_q == CNT_W'(SHORT_REG_WD - 1));
      default:                last_bit_c = 1'b0;
    endcase
  end

  assign field_done_c = spi_clk_rise_c & last_bit_c;

  // Next-state logic; a deselected chip select overrides everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (cs_fall_c) state_d = ST_CMD;
      ST_CMD:     if (field_done_c) state_d = cmd_valid_c ? ST_ADDR : ST_WAIT_CS;
      ST_ADDR:    if (field_done_c) state_d = is_rd_q ? ST_RD_DATA : ST_WR_DATA;
      ST_RD_DATA: if (field_done_c) state_d = ST_WAIT_CS;
      ST_WR_DATA: if (field_done_c) state_d = ST_WAIT_CS;
      ST_WAIT_CS: state_d = ST_WAIT_CS;
      default:    state_d = ST_IDLE;
    endcase
    if (cs_n_sync && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  // Read mux, priority fix > pix > frame
  always_comb begin
    rd_mux_c = '0;
    if (reg_bus.i_fix_sel)        rd_mux_c = reg_bus.iv_fix_rd_data;
    else if (reg_bus.i_pix_sel)   rd_mux_c = reg_bus.iv_pix_rd_data;
    else if (reg_bus.i_frame_sel) rd_mux_c = reg_bus.iv_frame_rd_data;
  end

  // State register, counters, shift registers and registered outputs
  always_ff @(posedge clk_sample or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      rx_sr_q    <= '0;
      tx_sr_q    <= '0;
      is_rd_q    <= 1'b0;
      load_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      o_spi_miso <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_d != state_q)  bit_cnt_q <= '0;
      else if (spi_clk_rise_c) bit_cnt_q <= bit_cnt_q + CNT_W'(1);

      if (spi_clk_rise_c) rx_sr_q <= rx_word_c[RX_W-2:0];

      if ((state_q == ST_CMD) && field_done_c)
        is_rd_q <= (cmd_word_c == CMD_WD'(CMD_RD));

      if ((state_q == ST_ADDR) && (state_d != ST_IDLE) && field_done_c)
        addr_q <= rx_word_c[SPI_ADDR_LENGTH-1:0];

      // Strobe only if the frame finished with chip select still asserted
      wr_en_q <= (state_q == ST_WR_DATA) && (state_d == ST_WAIT_CS);
      if ((state_q == ST_WR_DATA) && (state_d == ST_WAIT_CS))
        wr_data_q <= rx_word_c[SHORT_REG_WD-1:0];

      rd_en_q <= (state_d == ST_RD_DATA);
      // Lists answer combinationally to rd_en/addr; capture one cycle later
      load_q  <= (state_q == ST_ADDR) && (state_d == ST_RD_DATA);

      // MSB is presented at load; each fall re-presents the current MSB then shifts,
      // so the fall right after the address leaves the MSB in place for the host.
      if (state_d != ST_RD_DATA) begin
        tx_sr_q    <= '0;
        o_spi_miso <= 1'b0;
      end else if (load_q) begin
        tx_sr_q    <= rd_mux_c;
        o_spi_miso <= rd_mux_c[SHORT_REG_WD-1];
      end else if (spi_clk_fall_c) begin
        tx_sr_q    <= {tx_sr_q[SHORT_REG_WD-2:0], 1'b0};
        o_spi_miso <= tx_sr_q[SHORT_REG_WD-1];
      end
    end
  end

  assign reg_bus.o_rd_en    = rd_en_q;
  assign reg_bus.ov_addr    = addr_q;
  assign reg_bus.o_wr_en    = wr_en_q;
  assign reg_bus.ov_wr_data = wr_data_q;

endmodule
